wb_mem_arbiter2: RTL
====================

Name: wb_mem_arbiter2

Overview:
- Two-master to one-slave Wishbone arbiter for the zero-delay simulation memory and its FPGA equivalents.
- Lets the Zet CPU (master 0) and a secondary bus master (master 1; VGA fetch or DMA) share one 16-bit memory slave port.
- Grant is registered and round-robin; ownership is held for the full duration of the winning master's cyc.
- Slave-side signals are muxed from the registered grant.

Parameters:
- AW, 19, word address width (adr[AW:1]).
- DW, 16, data width; SEL width is DW/8.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  reset, asynchronous, active-low
- m0_dat_i / m1_dat_i  in  DW  master write data
- m0_dat_o / m1_dat_o  out  DW  read data to masters
- m0_adr_i / m1_adr_i  in  AW  word address, bits [AW:1]
- m0_we_i / m1_we_i  in  1  write enable
- m0_sel_i / m1_sel_i  in  DW/8  byte selects
- m0_stb_i / m1_stb_i  in  1  strobe
- m0_cyc_i / m1_cyc_i  in  1  cycle, used as request/lock
- m0_ack_o / m1_ack_o  out  1  acknowledge
- s_dat_o  out  DW  write data to slave
- s_dat_i  in  DW  read data from slave
- s_adr_o  out  AW  address to slave
- s_we_o  out  1  write enable to slave
- s_sel_o  out  DW/8  byte selects to slave
- s_stb_o  out  1  strobe to slave
- s_cyc_o  out  1  cycle to slave
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current owner ({m1,m0}); 00 when idle

Behaviour:
State machine, registered: IDLE, OWN0, OWN1, plus a 1-bit `last` pointer recording the last master granted.

Reset (wb_rst_i low, asynchronous):
- state=IDLE, last=1, so master 0 wins the first tie.
- All slave outputs are 0; gnt_o=00; m0_ack_o=m1_ack_o=0.

IDLE:
- Only m0_cyc_i high -> OWN0.
- Only m1_cyc_i high -> OWN1.
- Both high -> grant the master that is not `last`.
- Neither high -> stay in IDLE.
- On entering OWNx, last <= x.

OWNx:
- Stay while mx_cyc_i is high. A multi-beat or locked read-modify-write sequence is never broken.
- When mx_cyc_i is sampled low, the next state is decided that same edge:
  - other master's cyc high -> OWN(other) directly, no idle bubble;
  - otherwise -> IDLE.

Grant latency:
- A request arriving in IDLE is granted at the next rising edge.
- The slave sees cyc/stb in that cycle. Minimum latency from request to first slave strobe is 1 cycle.

Slave-side mux (combinational from the registered state):
- OWNx: s_adr/dat/we/sel_o = mx_*; s_cyc_o = mx_cyc_i; s_stb_o = mx_stb_i & mx_cyc_i.
- IDLE: all slave outputs 0.

Ack routing:
- mx_ack_o = s_ack_i & (state==OWNx) & mx_stb_i.
- The non-owner's ack is always 0. A slave ack with no owner is discarded.

Read data:
- m0_dat_o = m1_dat_o = s_dat_i, broadcast; only the acked master consumes it.

Handover cycle:
- When the owner drops cyc, the slave sees s_cyc_o=0 for that cycle (owner's cyc is low).
- The new owner's strobe appears the following cycle.
- No write from the departing master can be issued after its cyc falls.

Other rules:
- A non-owner holding stb/cyc is stalled (ack=0) indefinitely until granted. Masters must keep their signals stable while stalled.
- Reset asserted mid-transfer aborts immediately: state=IDLE, slave cyc/stb drop asynchronously. Any in-flight write is undefined at the slave.
- There are no width conversions. Addresses and data pass through unchanged.

Test Plan:
- Reset: hold wb_rst_i=0 with both cyc=1 -> gnt_o=00, s_cyc_o=0, acks 0. Release -> next edge gnt_o=01.
- Single master: m1 writes 0xBEEF to adr 0x00100, sel=11, m0 idle -> gnt_o=10 after 1 edge, s_adr_o=0x00100, m1_ack_o=1, m0_ack_o=0. Read back returns 0xBEEF on m1_dat_o.
- Tie round-robin: both request continuously, each dropping cyc after one beat -> grants alternate 01,10,01,10 with no IDLE cycles between owners.
- Lock: m0 holds cyc for 5 beats (stb pulsing) while m1 requests -> m1_ack_o stays 0 for all 5 beats. OWN1 is entered on the edge after m0 cyc falls.
- Byte write through arbiter: m0 writes 0x1234 then 0xAB00 with sel=10 to the same address -> readback 0xAB34.
- Mid-transfer reset: assert wb_rst_i=0 during an m1 burst -> s_cyc_o/s_stb_o fall without waiting for a clock. After release with both requesting, m0 is granted first.

Source files
------------

// File: rtl/wb_mem_arbiter2.sv
// Two-master to one-slave Wishbone arbiter with registered round-robin grant, held for the owner's whole cyc.
// Latency: a request in IDLE is granted on the next rising edge; slave signals are muxed combinationally from the grant.
// Backpressure: a non-owner is stalled (ack=0) until granted; the owner is throttled only by the slave's ack.
module wb_mem_arbiter2 #(
    parameter int AW = 19,
    parameter int DW = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic [DW-1:0]    m0_dat_i,
    output logic [DW-1:0]    m0_dat_o,
    input  logic [AW:1]      m0_adr_i,
    input  logic             m0_we_i,
    input  logic [DW/8-1:0]  m0_sel_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    output logic             m0_ack_o,

    input  logic [DW-1:0]    m1_dat_i,
    output logic [DW-1:0]    m1_dat_o,
    input  logic [AW:1]      m1_adr_i,
    input  logic             m1_we_i,
    input  logic [DW/8-1:0]  m1_sel_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    output logic             m1_ack_o,

    output logic [DW-1:0]    s_dat_o,
    input  logic [DW-1:0]    s_dat_i,
    output logic [AW:1]      s_adr_o,
    output logic             s_we_o,
    output logic [DW/8-1:0]  s_sel_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic             s_ack_i,

    output logic [1:0]       gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state;
    logic       last;   // master most recently granted; the other one wins a tie
    logic [1:0] gnt_q;

    // Grant FSM: ownership lasts for the owner's full cyc, hands over directly when the other master is waiting.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            gnt_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= OWN0;
                        last  <= 1'b0;
                        gnt_q <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state <= OWN1;
                        last  <= 1'b1;
                        gnt_q <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            state <= OWN1;
                            last  <= 1'b1;
                            gnt_q <= 2'b10;
                        end else begin
                            state <= IDLE;
                            gnt_q <= 2'b00;
                        end
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            state <= OWN0;
                            last  <= 1'b0;
                            gnt_q <= 2'b01;
                        end else begin
                            state <= IDLE;
                            gnt_q <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= 2'b00;
                end
            endcase
        end
    end

    assign gnt_o = gnt_q;

    // Slave-side mux driven from the registered owner; everything is quiet with no owner.
    always_comb begin
        s_dat_o = '0;
        s_adr_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        case (state)
            OWN0: begin
                s_dat_o = m0_dat_i;
                s_adr_o = m0_adr_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i & m0_cyc_i;
            end
            OWN1: begin
                s_dat_o = m1_dat_i;
                s_adr_o = m1_adr_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i & m1_cyc_i;
            end
            default: begin
            end
        endcase
    end

    // Only the owner sees the slave ack; an ack with no owner is dropped.
    assign m0_ack_o = s_ack_i & (state == OWN0) & m0_stb_i;
    assign m1_ack_o = s_ack_i & (state == OWN1) & m1_stb_i;

    // Read data is broadcast; only the acked master consumes it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
